// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - FSM state encoding for the fetch controller
//   - instruction field positions (TYP / OP / operand)
//   - HALT opcode and the controller's opcode enumeration
//   - 16-entry branch-target table consumed by branch_lut
package instr_fetch_pkg;

  localparam int LUT_W   = 10;  // width of the stored branch targets
  localparam int LUT_N   = 16;  // one entry per 4-bit operand value

  // Instruction layout: [8] TYP, [7:4] OP, [3:0] operand, [7:0] imm.
  localparam int TYP_BIT  = 8;
  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 4;
  localparam int OPND_MSB = 3;
  localparam int OPND_LSB = 0;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  localparam logic [3:0] HALT_OP = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  // Opcode map shared with the control unit. OP_RSVD is fetched like any
  // other instruction; only OP_HALT with TYP=0 stops the fetch stage.
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LD   = 4'h1,
    OP_ST   = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_BR   = 4'h5,
    OP_BZ   = 4'h6,
    OP_BNZ  = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'hA,
    OP_SHL  = 4'hB,
    OP_SHR  = 4'hC,
    OP_MOV  = 4'hD,
    OP_RSVD = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  // Branch targets indexed by the branch instruction's operand field.
  localparam logic [LUT_W-1:0] BR_LUT [LUT_N] = '{
    10'h000, 10'h010, 10'h018, 10'h040,
    10'h020, 10'h080, 10'h0C0, 10'h100,
    10'h140, 10'h180, 10'h1C0, 10'h200,
    10'h280, 10'h300, 10'h380, 10'h3F0
  };

  function automatic logic is_halt(input logic typ, input logic [3:0] op);
    return (typ == 1'b0) && (op == HALT_OP);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_addr : fetch address driven by the fetch stage (master)
//   imem_data : instruction word, combinational from imem_addr (slave)
interface instr_fetch_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
);

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;

  modport master (output imem_addr, input  imem_data);
  modport slave  (input  imem_addr, output imem_data);

endinterface

// File: rtl/instr_fetch_branch_lut.sv
// branch_lut: combinational branch-target lookup.
//   idx    : 4-bit operand of the branch instruction in IR
//   target : PC to redirect to when the branch is taken
module branch_lut
  import instr_fetch_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [3:0]      idx,
  output logic [PC_W-1:0] target
);

  // Table entries are LUT_W wide; resize to the PC width in use.
  assign target = PC_W'(BR_LUT[idx]);

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding the control unit.
//   clk, reset_n : clock and synchronous active-low reset
//   start        : pulse to (re)start execution from START_ADDR
//   stall        : freeze PC, IR, ir_pc and ir_valid while in RUN
//   br_taken     : branch resolved taken for the instruction in IR
//   imem         : instruction-memory bus (address out, data in)
//   ir_valid     : IR holds a live instruction
//   typ/op/operand/imm : IR fields, driven whether valid or not
//   ir_pc        : address the IR instruction came from
//   done         : high while HALTED
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              PC_W       = 10,
  parameter int              INSTR_W    = 9,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic             br_taken,
  instr_fetch_if.master    imem,
  output logic             ir_valid,
  output logic             typ,
  output logic [3:0]       op,
  output logic [3:0]       operand,
  output logic [7:0]       imm,
  output logic [PC_W-1:0]  ir_pc,
  output logic             done
);

  state_e             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    br_target;
  logic               ir_is_halt;

  branch_lut #(.PC_W(PC_W)) u_branch_lut (
    .idx    (operand),
    .target (br_target)
  );

  assign imem.imem_addr = pc;

  assign typ     = ir[TYP_BIT];
  assign op      = ir[OP_MSB:OP_LSB];
  assign operand = ir[OPND_MSB:OPND_LSB];
  assign imm     = ir[IMM_MSB:IMM_LSB];

  assign ir_is_halt = is_halt(typ, op);

  // NOTE: reset is sampled inside the clocked block (synchronous), and every
  // state register uses <= so all of them update together on the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= START_ADDR;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            pc       <= START_ADDR;
            ir_valid <= 1'b0;
          end
        end

        RUN: begin
          // While stalled everything holds, including a pending br_taken;
          // the controller keeps it asserted until the stall releases.
          if (!stall) begin
            if (ir_valid && ir_is_halt) begin
              state    <= HALTED;
              ir_valid <= 1'b0;
              done     <= 1'b1;
            end else if (ir_valid && br_taken) begin
              // Drop the wrong-path fetch: exactly one bubble.
              pc       <= br_target;
              ir_valid <= 1'b0;
            end else begin
              ir       <= imem.imem_data;
              ir_pc    <= pc;
              ir_valid <= 1'b1;
              pc       <= pc + 1'b1;  // wraps modulo 2^PC_W
            end
          end
        end

        HALTED: begin
          if (start) begin
            state <= RUN;
            pc    <= START_ADDR;
            done  <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          ir_valid <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch. A stimulus process drives directed sequences
// and pushes the expected instruction stream into a queue; monitor
// processes pop and compare whenever the DUT presents a consumed IR.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (START_ADDR = 0)
  logic       reset_n, start, stall, br_taken;
  logic       ir_valid, typ, done;
  logic [3:0] op, operand;
  logic [7:0] imm;
  logic [9:0] ir_pc;

  // Wrap DUT (START_ADDR = 3FE)
  logic       reset_n_w, start_w;
  logic       ir_valid_w, typ_w, done_w;
  logic [3:0] op_w, operand_w;
  logic [7:0] imm_w;
  logic [9:0] ir_pc_w;

  instr_fetch_if #(.PC_W(10), .INSTR_W(9)) bus   ();
  instr_fetch_if #(.PC_W(10), .INSTR_W(9)) bus_w ();

  logic [8:0] mem [1024];

  assign bus.imem_data   = mem[bus.imem_addr];
  assign bus_w.imem_data = mem[bus_w.imem_addr];

  instr_fetch #(.PC_W(10), .INSTR_W(9), .START_ADDR(10'h000)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .stall    (stall),
    .br_taken (br_taken),
    .imem     (bus),
    .ir_valid (ir_valid),
    .typ      (typ),
    .op       (op),
    .operand  (operand),
    .imm      (imm),
    .ir_pc    (ir_pc),
    .done     (done)
  );

  instr_fetch #(.PC_W(10), .INSTR_W(9), .START_ADDR(10'h3FE)) dut_w (
    .clk      (clk),
    .reset_n  (reset_n_w),
    .start    (start_w),
    .stall    (1'b0),
    .br_taken (1'b0),
    .imem     (bus_w),
    .ir_valid (ir_valid_w),
    .typ      (typ_w),
    .op       (op_w),
    .operand  (operand_w),
    .imm      (imm_w),
    .ir_pc    (ir_pc_w),
    .done     (done_w)
  );

  typedef struct packed {
    logic [8:0] instr;
    logic [9:0] pc;
  } exp_t;

  exp_t q[$];
  exp_t qw[$];
  exp_t m_e, mw_e;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Program image: hand-placed instructions, filler elsewhere (TYP=1, never HALT).
  function automatic logic [8:0] prog(input int a);
    case (a)
      0:       return 9'h0A3;
      1:       return 9'h1FF;  // TYP=1, OP=F: not a HALT
      2:       return 9'h012;
      7:       return 9'h054;  // branch, operand 4 -> lut[4]=020
      'h20:    return 9'h0E1;  // reserved opcode, fetched normally
      'h21:    return 9'h153;  // branch, operand 3 -> lut[3]=040
      'h40:    return 9'h0F0;  // HALT
      default: return 9'h100 | 9'(a);
    endcase
  endfunction

  task automatic push(input int a);
    q.push_back('{instr: prog(a), pc: 10'(a)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: an IR is consumed on a cycle where it is valid and not stalled.
  always @(negedge clk) begin
    if (ir_valid === 1'b1 && stall === 1'b0) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_extra: got ir=%0h ir_pc=%0h expected no instruction",
                 {typ, op, operand}, ir_pc);
      end else begin
        m_e = q.pop_front();
        check("mon_ir",    {23'd0, typ, op, operand}, {23'd0, m_e.instr});
        check("mon_imm",   {24'd0, imm},              {24'd0, m_e.instr[7:0]});
        check("mon_ir_pc", {22'd0, ir_pc},            {22'd0, m_e.pc});
      end
    end
  end

  always @(negedge clk) begin
    if (ir_valid_w === 1'b1) begin
      if (qw.size() == 0) begin
        total++;
        bad++;
        $display("FAIL monw_extra: got ir=%0h ir_pc=%0h expected no instruction",
                 {typ_w, op_w, operand_w}, ir_pc_w);
      end else begin
        mw_e = qw.pop_front();
        check("monw_ir",    {23'd0, typ_w, op_w, operand_w}, {23'd0, mw_e.instr});
        check("monw_ir_pc", {22'd0, ir_pc_w},                {22'd0, mw_e.pc});
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    stall     = 1'b0;
    br_taken  = 1'b0;
    reset_n_w = 1'b0;
    start_w   = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = prog(i);

    // Reset state
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("rst_addr",  bus.imem_addr, 10'h000);
    check("rst_valid", ir_valid, 1'b0);
    check("rst_done",  done, 1'b0);
    check("rst_ir_pc", ir_pc, 10'h000);
    check("rst_ir",    {typ, op, operand}, 9'h000);

    // Start and fetch latency
    for (int a = 0; a <= 7; a++) push(a);
    push('h20);
    push('h21);
    push('h40);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lat_valid_edge1", ir_valid, 1'b0);
    check("lat_addr_edge1",  bus.imem_addr, 10'h000);
    tick();
    check("lat_valid_edge2", ir_valid, 1'b1);
    check("lat_addr_edge2",  bus.imem_addr, 10'h001);
    check("lat_ir_pc_edge2", ir_pc, 10'h000);
    tick();
    check("seq_addr2", bus.imem_addr, 10'h002);
    tick();
    check("seq_addr3", bus.imem_addr, 10'h003);

    // Taken branch at ir_pc=7
    for (int i = 0; i < 20 && !(ir_valid === 1'b1 && ir_pc == 10'h007); i++) tick();
    check("br_reach_pc", ir_pc, 10'h007);
    check("br_op",       op, 4'h5);
    check("br_operand",  operand, 4'h4);
    br_taken = 1'b1;
    tick();
    br_taken = 1'b0;
    check("br_bubble_valid", ir_valid, 1'b0);
    check("br_bubble_addr",  bus.imem_addr, 10'h020);
    tick();
    check("br_target_valid", ir_valid, 1'b1);
    check("br_target_ir_pc", ir_pc, 10'h020);
    check("rsvd_op",         op, 4'hE);
    tick();
    check("br2_ir_pc", ir_pc, 10'h021);

    // Stall with branch held for three edges
    stall    = 1'b1;
    br_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_addr",  bus.imem_addr, 10'h022);
      check("stall_ir_pc", ir_pc, 10'h021);
      check("stall_ir",    {typ, op, operand}, 9'h153);
      check("stall_valid", ir_valid, 1'b1);
    end
    stall = 1'b0;
    tick();
    br_taken = 1'b0;
    check("stall_br_valid", ir_valid, 1'b0);
    check("stall_br_addr",  bus.imem_addr, 10'h040);

    // HALT
    tick();
    check("halt_fetched", ir_pc, 10'h040);
    check("halt_pre_done", done, 1'b0);
    tick();
    check("halt_done",  done, 1'b1);
    check("halt_valid", ir_valid, 1'b0);
    check("halt_addr",  bus.imem_addr, 10'h041);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("halt_frozen_addr", bus.imem_addr, 10'h041);
      check("halt_frozen_done", done, 1'b1);
    end

    // Restart from HALTED, then reset mid-run at pc=015
    for (int a = 0; a <= 'h14; a++) push(a);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_done",  done, 1'b0);
    check("restart_addr",  bus.imem_addr, 10'h000);
    check("restart_valid", ir_valid, 1'b0);
    for (int i = 0; i < 60 && bus.imem_addr != 10'h015; i++) tick();
    check("mid_reach_pc", bus.imem_addr, 10'h015);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_addr",  bus.imem_addr, 10'h000);
    check("mid_rst_valid", ir_valid, 1'b0);
    check("mid_rst_done",  done, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("idle_addr",  bus.imem_addr, 10'h000);
      check("idle_valid", ir_valid, 1'b0);
    end
    check("q_drained", q.size(), 0);

    // PC wrap on the START_ADDR=3FE instance
    reset_n_w = 1'b1;
    qw.push_back('{instr: prog('h3FE), pc: 10'h3FE});
    qw.push_back('{instr: prog('h3FF), pc: 10'h3FF});
    qw.push_back('{instr: prog(0),     pc: 10'h000});
    tick();
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    check("wrap_start_addr", bus_w.imem_addr, 10'h3FE);
    for (int i = 0; i < 10 && qw.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    reset_n_w = 1'b0;
    check("wrap_drained", qw.size(), 0);
    check("wrap_addr",    bus_w.imem_addr, 10'h001);
    tick();
    check("wrap_rst_valid", ir_valid_w, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
